// File: rtl/mesh_pkg.sv
// -----------------------------------------------------------------------------
// mesh_pkg
//  Shared definitions for the mesh terminal injector: packet field widths,
//  the broadcast code, the buffer-status FSM encoding, the destination
//  legality helper and the packet header builder.
// -----------------------------------------------------------------------------
package mesh_pkg;

  localparam int JUMP_W = 8;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 4;
  localparam int MODE_W = 1;
  // Everything in front of the payload: nxt_jump, row, col, mode.
  localparam int HDR_W  = JUMP_W + ROW_W + COL_W + MODE_W;

  localparam logic [ROW_W+COL_W-1:0] BDCST_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_PART  = 2'd1,
    ST_FULL  = 2'd2
  } inj_state_e;

  typedef struct packed {
    logic [JUMP_W-1:0] jump;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic              mode;
  } pkt_hdr_t;

  // Terminals sit on the ring around the mesh: rows 0 / rows+1 along the top
  // and bottom edges, columns 0 / columns+1 along the sides. The four corners
  // and every interior router coordinate have no terminal attached.
  function automatic logic is_legal_dest(
    input logic [ROW_W-1:0]       row,
    input logic [COL_W-1:0]       col,
    input int                     rows,
    input int                     columns,
    input logic [ROW_W+COL_W-1:0] bdcst = BDCST_DEF
  );
    int   r;
    int   c;
    logic on_row_edge;
    logic on_col_edge;
    r = int'(row);
    c = int'(col);
    on_row_edge = ((r == 0) || (r == rows + 1)) && (c >= 1) && (c <= columns);
    on_col_edge = ((c == 0) || (c == columns + 1)) && (r >= 1) && (r <= rows);
    return ({row, col} == bdcst) || on_row_edge || on_col_edge;
  endfunction

  // nxt_jump is left zero; the router fills it in.
  function automatic pkt_hdr_t build_hdr(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col,
    input logic             mode
  );
    pkt_hdr_t h;
    h.jump = '0;
    h.row  = row;
    h.col  = col;
    h.mode = mode;
    return h;
  endfunction

endpackage

// File: rtl/mesh_term_injector_if.sv
// -----------------------------------------------------------------------------
// mesh_term_injector_if
//  Bundles the host request channel (valid/ready + destination/mode/payload)
//  and the router-facing FWFT channel (pndng/data/popin).
//  master : the agent side (host drives requests, router drives popin)
//  slave  : the injector
// -----------------------------------------------------------------------------
interface mesh_term_injector_if #(
  parameter int PAKG_SIZE = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [3:0]           req_row;
  logic [3:0]           req_col;
  logic                 req_mode;
  logic [PAKG_SIZE-18:0] req_pyld;

  logic                 pndng;
  logic [PAKG_SIZE-1:0] data;
  logic                 popin;

  modport master (
    output req_valid, req_row, req_col, req_mode, req_pyld, popin,
    input  req_ready, pndng, data
  );

  modport slave (
    input  req_valid, req_row, req_col, req_mode, req_pyld, popin,
    output req_ready, pndng, data
  );
endinterface

// File: rtl/mesh_inj_fifo.sv
// -----------------------------------------------------------------------------
// mesh_inj_fifo
//  First-word-fall-through synchronous FIFO. The head entry is visible on
//  dout_o combinationally from storage; a push becomes visible through
//  count/empty one cycle later (no empty bypass).
//  Ports:
//    clk_i, rst_i (async, active-low)
//    push_i/din_i : write request (ignored when full)
//    pop_i        : remove head (ignored when empty)
//    dout_o       : entry at read pointer
//    full_o, empty_o, count_o : occupancy from the registered count
// -----------------------------------------------------------------------------
module mesh_inj_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;  // DEPTH is a power of two: natural wrap
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so data_o reads zero straight out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mesh_term_injector.sv
// -----------------------------------------------------------------------------
// mesh_term_injector
//  Terminal-side injection stage in front of one mesh router input port.
//  Host requests are legality-checked, formatted into router packets and
//  buffered in an FWFT FIFO whose head drives the router's pndng/data pair.
//  Ports:
//    clk_i, rst_i (async, active-low)
//    bus        : slave side of mesh_term_injector_if (request + router channel)
//    err_o      : sticky, set once an illegal destination has been rejected
//    inj_cnt_o  : packets written into the buffer (wraps)
//    rej_cnt_o  : requests rejected as illegal (wraps)
// -----------------------------------------------------------------------------
module mesh_term_injector
  import mesh_pkg::*;
#(
  parameter int         ROWS       = 4,
  parameter int         COLUMNS    = 4,
  parameter int         PAKG_SIZE  = 32,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] BDCST      = 8'hFF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mesh_term_injector_if.slave  bus,
  output logic                 err_o,
  output logic [15:0]          inj_cnt_o,
  output logic [15:0]          rej_cnt_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  inj_state_e           state_q, state_d;
  logic [15:0]          inj_cnt_q, inj_cnt_d;
  logic [15:0]          rej_cnt_q, rej_cnt_d;
  logic                 err_q, err_d;

  logic                 legal;
  logic                 handshake;
  logic                 push;
  logic                 pop;
  logic                 ready;
  pkt_hdr_t             hdr;
  logic [PAKG_SIZE-1:0] pkt;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  assign legal     = is_legal_dest(bus.req_row, bus.req_col, ROWS, COLUMNS, BDCST);
  assign handshake = bus.req_valid && ready;
  assign push      = handshake && legal;
  assign pop       = bus.popin && !fifo_empty;

  assign hdr = build_hdr(bus.req_row, bus.req_col, bus.req_mode);
  assign pkt = {hdr, bus.req_pyld};

  mesh_inj_fifo #(
    .WIDTH (PAKG_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (pkt),
    .pop_i   (bus.popin),
    .dout_o  (bus.data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.pndng   = !fifo_empty;
  assign bus.req_ready = ready;
  assign err_o       = err_q;
  assign inj_cnt_o   = inj_cnt_q;
  assign rej_cnt_o   = rej_cnt_q;

  // ---------------- status FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- status FSM: next state ----------------
  // Transitions look at the registered count plus this cycle's push/pop,
  // so FULL/EMPTY are entered on the same edge the count reaches the bound.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_PART;
      end
      ST_PART: begin
        if (push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH - 1))) begin
          state_d = ST_FULL;
        end else if (pop && !push && (fifo_count == CNT_W'(1))) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) state_d = ST_PART;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // ---------------- status FSM: outputs ----------------
  // Ready is held low through reset; otherwise it drops only when the buffer
  // is full (both the FSM and the FIFO's own count agree on that).
  always_comb begin
    ready = 1'b0;
    if (rst_i && (state_q != ST_FULL) && !fifo_full) begin
      ready = 1'b1;
    end
  end

  // ---------------- counters and sticky error ----------------
  always_comb begin
    inj_cnt_d = inj_cnt_q;
    rej_cnt_d = rej_cnt_q;
    err_d     = err_q;
    if (push) begin
      inj_cnt_d = inj_cnt_q + 16'd1;
    end
    if (handshake && !legal) begin
      rej_cnt_d = rej_cnt_q + 16'd1;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inj_cnt_q <= '0;
      rej_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      inj_cnt_q <= inj_cnt_d;
      rej_cnt_q <= rej_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mesh_term_injector.sv
// -----------------------------------------------------------------------------
// tb_mesh_term_injector
//  Directed bench for mesh_term_injector. Inputs are driven and outputs
//  sampled on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_mesh_term_injector;

  localparam int PS = 32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        err_o;
  logic [15:0] inj_cnt_o;
  logic [15:0] rej_cnt_o;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_inj      = 0;
  int exp_rej      = 0;

  mesh_term_injector_if #(.PAKG_SIZE(PS)) bus ();

  mesh_term_injector #(
    .ROWS       (4),
    .COLUMNS    (4),
    .PAKG_SIZE  (PS),
    .FIFO_DEPTH (16),
    .BDCST      (8'hFF)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus),
    .err_o     (err_o),
    .inj_cnt_o (inj_cnt_o),
    .rej_cnt_o (rej_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected router packet: 8'h00 jump, row, col, mode, 15-bit payload.
  function automatic logic [31:0] pkt_of(input logic [3:0] row, input logic [3:0] col,
                                         input logic mode, input logic [14:0] pyld);
    return {8'h00, row, col, mode, pyld};
  endfunction

  // Present a request and hold it until accepted (bounded).
  task automatic send(input logic [3:0] row, input logic [3:0] col, input logic mode,
                      input logic [14:0] pyld, input bit legal);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_row   = row;
    bus.req_col   = col;
    bus.req_mode  = mode;
    bus.req_pyld  = pyld;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("send_accept", 32'(n < 200), 32'd1);
    @(negedge clk_i);
    bus.req_valid = 1'b0;
    if (n < 200) begin
      if (legal) exp_inj++;
      else       exp_rej++;
    end
    $display("[TB] req row=%0d col=%0d mode=%0d pyld=0x%04h legal=%0d", row, col, mode, pyld, legal);
  endtask

  // Check head and pop it for one cycle.
  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk({tag, "_pndng"}, 32'(bus.pndng), 32'd1);
    chk(tag, bus.data, exp);
    bus.popin = 1'b1;
    @(negedge clk_i);
    bus.popin = 1'b0;
    $display("[TB] pop data=0x%08h", exp);
  endtask

  initial begin
    logic [31:0] d;
    bus.req_valid = 1'b0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.req_mode  = 1'b0;
    bus.req_pyld  = '0;
    bus.popin     = 1'b0;

    // ---- reset state ----
    #3;
    chk("rst_pndng", 32'(bus.pndng), 32'd0);
    chk("rst_data",  bus.data, 32'd0);
    chk("rst_err",   32'(err_o), 32'd0);
    chk("rst_inj",   32'(inj_cnt_o), 32'd0);
    chk("rst_rej",   32'(rej_cnt_o), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

    // ---- single legal request ----
    send(4'd0, 4'd2, 1'b1, 15'h1234, 1'b1);
    chk("single_data_const", bus.data, 32'h0002_9234);
    pop_chk("single", 32'h0002_9234);
    chk("single_empty", 32'(bus.pndng), 32'd0);
    chk("single_inj", 32'(inj_cnt_o), 32'd1);

    // ---- illegal destinations (interior, corners) ----
    send(4'd2, 4'd2, 1'b0, 15'h0001, 1'b0);
    send(4'd0, 4'd0, 1'b0, 15'h0002, 1'b0);
    chk("illegal_pndng", 32'(bus.pndng), 32'd0);
    chk("illegal_rej2",  32'(rej_cnt_o), 32'd2);
    chk("illegal_err",   32'(err_o), 32'd1);
    send(4'd5, 4'd5, 1'b0, 15'h0003, 1'b0);
    send(4'd5, 4'd0, 1'b0, 15'h0004, 1'b0);
    chk("corner_pndng", 32'(bus.pndng), 32'd0);
    chk("corner_rej",   32'(rej_cnt_o), 32'(exp_rej));
    chk("corner_inj",   32'(inj_cnt_o), 32'(exp_inj));

    // ---- edge-boundary legal destinations ----
    send(4'd5, 4'd4, 1'b0, 15'h0007, 1'b1);
    send(4'd3, 4'd5, 1'b1, 15'h7FFF, 1'b1);
    pop_chk("edge_54", 32'h0054_0007);
    pop_chk("edge_35", 32'h0035_FFFF);
    chk("edge_empty", 32'(bus.pndng), 32'd0);

    // ---- broadcast ----
    send(4'hF, 4'hF, 1'b0, 15'h0055, 1'b1);
    d = bus.data;
    chk("bdcst_rc", 32'(d[23:16]), 32'h0000_00FF);
    pop_chk("bdcst", 32'h00FF_0055);

    // ---- fill to full, hold 17th, drain in order ----
    for (int i = 0; i < 16; i++) begin
      send(4'd0, 4'd1, 1'b0, 15'(i), 1'b1);
    end
    chk("full_ready", 32'(bus.req_ready), 32'd0);
    chk("full_pndng", 32'(bus.pndng), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_row   = 4'd0;
    bus.req_col   = 4'd1;
    bus.req_mode  = 1'b0;
    bus.req_pyld  = 15'd16;
    repeat (3) @(negedge clk_i);
    chk("held_ready", 32'(bus.req_ready), 32'd0);
    chk("held_inj",   32'(inj_cnt_o), 32'(exp_inj));
    pop_chk("drain_0", pkt_of(4'd0, 4'd1, 1'b0, 15'd0));
    send(4'd0, 4'd1, 1'b0, 15'd16, 1'b1);
    chk("refill_ready", 32'(bus.req_ready), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      pop_chk($sformatf("drain_%0d", i), pkt_of(4'd0, 4'd1, 1'b0, 15'(i)));
    end
    chk("drain_empty", 32'(bus.pndng), 32'd0);
    chk("drain_inj",   32'(inj_cnt_o), 32'(exp_inj));

    // ---- simultaneous push+pop at count 8 ----
    for (int i = 0; i < 8; i++) begin
      send(4'd0, 4'd3, 1'b0, 15'(100 + i), 1'b1);
    end
    for (int k = 0; k < 20; k++) begin
      bus.req_valid = 1'b1;
      bus.req_row   = 4'd0;
      bus.req_col   = 4'd3;
      bus.req_mode  = 1'b0;
      bus.req_pyld  = 15'(108 + k);
      bus.popin     = 1'b1;
      chk("pp_ready", 32'(bus.req_ready), 32'd1);
      chk("pp_pndng", 32'(bus.pndng), 32'd1);
      chk($sformatf("pp_head_%0d", k), bus.data, pkt_of(4'd0, 4'd3, 1'b0, 15'(100 + k)));
      @(negedge clk_i);
      exp_inj++;
      $display("[TB] push+pop pyld=%0d", 108 + k);
    end
    bus.req_valid = 1'b0;
    bus.popin     = 1'b0;
    for (int j = 0; j < 8; j++) begin
      pop_chk($sformatf("pp_drain_%0d", j), pkt_of(4'd0, 4'd3, 1'b0, 15'(120 + j)));
    end
    chk("pp_empty", 32'(bus.pndng), 32'd0);
    chk("pp_inj",   32'(inj_cnt_o), 32'(exp_inj));

    // ---- pop while empty is ignored ----
    bus.popin = 1'b1;
    @(negedge clk_i);
    bus.popin = 1'b0;
    chk("epop_pndng", 32'(bus.pndng), 32'd0);
    chk("epop_inj",   32'(inj_cnt_o), 32'(exp_inj));
    send(4'd0, 4'd4, 1'b0, 15'h0042, 1'b1);
    pop_chk("epop_after", pkt_of(4'd0, 4'd4, 1'b0, 15'h0042));

    // ---- asynchronous reset mid-fill ----
    for (int i = 0; i < 5; i++) begin
      send(4'd5, 4'd2, 1'b1, 15'(200 + i), 1'b1);
    end
    chk("mid_pndng", 32'(bus.pndng), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_pndng", 32'(bus.pndng), 32'd0);
    chk("arst_data",  bus.data, 32'd0);
    chk("arst_inj",   32'(inj_cnt_o), 32'd0);
    chk("arst_rej",   32'(rej_cnt_o), 32'd0);
    chk("arst_err",   32'(err_o), 32'd0);
    chk("arst_ready", 32'(bus.req_ready), 32'd0);
    exp_inj = 0;
    exp_rej = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_pndng", 32'(bus.pndng), 32'd0);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    send(4'd1, 4'd0, 1'b1, 15'h0BAD, 1'b1);
    pop_chk("post_rst", pkt_of(4'd1, 4'd0, 1'b1, 15'h0BAD));
    chk("post_rst_inj", 32'(inj_cnt_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
